// File: rtl/sseg_scan_ctrl_if.sv
// Connection bundle between the value producer and the seven-segment scan controller.
// The master side supplies data and enables. The slave side drives the display pins and the pending flag.
interface sseg_scan_ctrl_if;
  logic        load;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [7:0]  en_mask;
  logic        pending;
  logic [7:0]  AN;
  logic [6:0]  sseg;
  logic        DP;

  modport master (
    output load, data_in, dp_in, en_mask,
    input  pending, AN, sseg, DP
  );

  modport slave (
    input  load, data_in, dp_in, en_mask,
    output pending, AN, sseg, DP
  );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// Eight-digit common-anode scan controller. It holds a pending/display register pair and commits on frame boundaries.
// Optional macro LEADING_ZERO_BLANK_EN darkens the digits above the most significant nonzero nibble.
module sseg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  sseg_scan_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LIT  = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [31:0]      pend_data;
  logic [7:0]       pend_dp;
  logic [31:0]      disp_data;
  logic [7:0]       disp_dp;
  logic             pending_q;
  logic [7:0]       digit_on;

  logic             slot_end;
  logic             frame_end;
  logic             commit;

  logic [7:0]       an_d;
  logic [6:0]       sseg_d;
  logic             dp_d;
  logic [7:0]       an_q;
  logic [6:0]       sseg_q;
  logic             dp_q;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == 3'd7);
  assign commit    = frame_end && pending_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // The commit copies the old pending value, so a load in the same cycle survives for the next frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_data <= '0;
      pend_dp   <= '0;
      pending_q <= 1'b0;
      disp_data <= '0;
      disp_dp   <= '0;
    end else begin
      if (commit) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
        pending_q <= 1'b0;
      end
      if (bus.load) begin
        pend_data <= bus.data_in;
        pend_dp   <= bus.dp_in;
        pending_q <= 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  function automatic logic [7:0] keep_digits(input logic [31:0] v);
    logic [7:0] k;
    k[7] = |v[31:28];
    for (int i = 6; i >= 0; i--) begin
      k[i] = k[i+1] | (|v[4*i +: 4]);
    end
    k[0] = 1'b1;
    return k;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_on <= 8'h01;
    end else if (commit) begin
      digit_on <= keep_digits(pend_data);
    end
  end
`else
  assign digit_on = 8'hFF;
`endif

  always_comb begin
    an_d   = 8'hFF;
    sseg_d = 7'h7F;
    dp_d   = 1'b1;
    if ((cnt >= CNT_LIT) && bus.en_mask[idx] && digit_on[idx]) begin
      an_d   = ~(8'b1 << idx);
      sseg_d = decode(disp_data[{idx, 2'b00} +: 4]);
      dp_d   = ~disp_dp[idx];
    end
  end

  // The pins are registered so that AN, sseg and DP switch together and no input reaches them combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_q   <= 8'hFF;
      sseg_q <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      an_q   <= an_d;
      sseg_q <= sseg_d;
      dp_q   <= dp_d;
    end
  end

  assign bus.AN      = an_q;
  assign bus.sseg    = sseg_q;
  assign bus.DP      = dp_q;
  assign bus.pending = pending_q;
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl with REFRESH_DIV=4, BLANK_CYCLES=1.
// A frame-position model is checked every cycle, and directed literal checks are made at chosen slots.
module tb_sseg_scan_ctrl;
  localparam int REFRESH_DIV  = 4;
  localparam int BLANK_CYCLES = 1;
  localparam int FRAME        = 8 * REFRESH_DIV;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  sseg_scan_ctrl_if bus();

  sseg_scan_ctrl #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int          t           = 0;
  bit          started     = 1'b0;
  logic [31:0] m_pend_data = '0;
  logic [7:0]  m_pend_dp   = '0;
  logic [31:0] m_disp_data = '0;
  logic [7:0]  m_disp_dp   = '0;
  bit          m_pending   = 1'b0;
  logic [15:0] exp_out     = 16'hFFFF;

  function automatic bit shown(input logic [31:0] value, input int dig);
`ifdef LEADING_ZERO_BLANK_EN
    return (dig == 0) || ((value >> (4 * dig)) != 32'd0);
`else
    return 1'b1;
`endif
  endfunction

  // The digit and slot position come from the cycle count since reset. The result is packed as {AN, sseg, DP}.
  function automatic logic [15:0] model_out(input int pos, input logic [7:0] mask,
                                            input logic [31:0] value, input logic [7:0] dps);
    int         slot;
    int         dig;
    logic [3:0] nib;
    slot = pos % REFRESH_DIV;
    dig  = (pos / REFRESH_DIV) % 8;
    nib  = 4'(value >> (4 * dig));
    if (slot >= BLANK_CYCLES && mask[dig] && shown(value, dig))
      return {~(8'd1 << dig), seg_tab[nib], ~dps[dig]};
    return 16'hFFFF;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      t           = 0;
      m_pend_data = '0;
      m_pend_dp   = '0;
      m_disp_data = '0;
      m_disp_dp   = '0;
      m_pending   = 1'b0;
      exp_out     = 16'hFFFF;
      started     = 1'b1;
    end else begin
      exp_out = model_out(t, bus.en_mask, m_disp_data, m_disp_dp);
      if ((t % FRAME) == FRAME - 1 && m_pending) begin
        m_disp_data = m_pend_data;
        m_disp_dp   = m_pend_dp;
        m_pending   = 1'b0;
      end
      if (bus.load) begin
        m_pend_data = bus.data_in;
        m_pend_dp   = bus.dp_in;
        m_pending   = 1'b1;
      end
      t++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (started) begin
      checkOutput("cyc_AN", 32'(bus.AN), 32'(exp_out[15:8]));
      checkOutput("cyc_sseg", 32'(bus.sseg), 32'(exp_out[7:1]));
      checkOutput("cyc_DP", 32'(bus.DP), 32'(exp_out[0]));
      checkOutput("cyc_pending", 32'(bus.pending), 32'(m_pending));
    end
  end

  task automatic applyStimulus(input logic ld, input logic [31:0] d, input logic [7:0] dp,
                               input logic [7:0] mask);
    bus.load    = ld;
    bus.data_in = d;
    bus.dp_in   = dp;
    bus.en_mask = mask;
  endtask

  task automatic pulseLoad(input logic [31:0] d, input logic [7:0] dp);
    applyStimulus(1'b1, d, dp, bus.en_mask);
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_state(input int k);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 2 * FRAME && !hit; n++) begin
      @(negedge clk);
      if ((t % FRAME) == k) hit = 1'b1;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_state: got timeout expected state %0d", k);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 32'h0, 8'h00, 8'hFF);
    repeat (3) @(negedge clk);
    checkOutput("rst_AN", 32'(bus.AN), 32'h FF);
    checkOutput("rst_sseg", 32'(bus.sseg), 32'h7F);
    checkOutput("rst_DP", 32'(bus.DP), 32'h1);
    checkOutput("rst_pending", 32'(bus.pending), 32'h0);
    reset_n = 1'b1;

    wait_state(2);
    checkOutput("boot_AN", 32'(bus.AN), 32'hFE);
    checkOutput("boot_sseg", 32'(bus.sseg), 32'b1000000);
    checkOutput("boot_DP", 32'(bus.DP), 32'h1);

    $display("[TB] basic scan");
    pulseLoad(32'h89ABCDEF, 8'h01);
    checkOutput("load_pending", 32'(bus.pending), 32'h1);
    wait_state(1);
    checkOutput("slot0_dark_AN", 32'(bus.AN), 32'hFF);
    checkOutput("commit_pending", 32'(bus.pending), 32'h0);
    wait_state(2);
    checkOutput("d0_AN", 32'(bus.AN), 32'hFE);
    checkOutput("d0_sseg", 32'(bus.sseg), 32'b0001110);
    checkOutput("d0_DP", 32'(bus.DP), 32'h0);
    wait_state(30);
    checkOutput("d7_AN", 32'(bus.AN), 32'h7F);
    checkOutput("d7_sseg", 32'(bus.sseg), 32'b0000000);
    checkOutput("d7_DP", 32'(bus.DP), 32'h1);

    $display("[TB] masking");
    applyStimulus(1'b0, 32'h89ABCDEF, 8'h01, 8'h0F);
    wait_state(2);
    checkOutput("mask_d0_AN", 32'(bus.AN), 32'hFE);
    wait_state(18);
    checkOutput("mask_d4_AN", 32'(bus.AN), 32'hFF);
    checkOutput("mask_d4_sseg", 32'(bus.sseg), 32'h7F);
    applyStimulus(1'b0, 32'h0, 8'h00, 8'hFF);

    $display("[TB] simultaneous load and commit");
    wait_state(10);
    pulseLoad(32'h0000000A, 8'h00);
    wait_state(31);
    pulseLoad(32'h0000000B, 8'h00);
    wait_state(2);
    checkOutput("simA_sseg", 32'(bus.sseg), 32'b0001000);
    checkOutput("simA_pending", 32'(bus.pending), 32'h1);
    wait_state(2);
    checkOutput("simB_sseg", 32'(bus.sseg), 32'b0000011);
    checkOutput("simB_pending", 32'(bus.pending), 32'h0);

    $display("[TB] overwrite");
    wait_state(5);
    pulseLoad(32'h1, 8'h00);
    wait_state(9);
    pulseLoad(32'h2, 8'h00);
    wait_state(2);
    checkOutput("ovw_AN", 32'(bus.AN), 32'hFE);
    checkOutput("ovw_sseg", 32'(bus.sseg), 32'b0100100);

    $display("[TB] leading zeros");
    wait_state(5);
    pulseLoad(32'h00000120, 8'h00);
    wait_state(2);
    checkOutput("lz_d0_sseg", 32'(bus.sseg), 32'b1000000);
    wait_state(10);
    checkOutput("lz_d2_AN", 32'(bus.AN), 32'hFB);
    checkOutput("lz_d2_sseg", 32'(bus.sseg), 32'b1111001);
    wait_state(14);
`ifdef LEADING_ZERO_BLANK_EN
    checkOutput("lz_d3_AN", 32'(bus.AN), 32'hFF);
`else
    checkOutput("lz_d3_AN", 32'(bus.AN), 32'hF7);
    checkOutput("lz_d3_sseg", 32'(bus.sseg), 32'b1000000);
`endif
    wait_state(20);
    pulseLoad(32'h0, 8'h00);
    wait_state(2);
    checkOutput("zero_d0_AN", 32'(bus.AN), 32'hFE);
    checkOutput("zero_d0_sseg", 32'(bus.sseg), 32'b1000000);
    wait_state(6);
`ifdef LEADING_ZERO_BLANK_EN
    checkOutput("zero_d1_AN", 32'(bus.AN), 32'hFF);
`else
    checkOutput("zero_d1_AN", 32'(bus.AN), 32'hFD);
`endif

    $display("[TB] reset mid-frame");
    wait_state(5);
    pulseLoad(32'hDEADBEEF, 8'hFF);
    checkOutput("prerst_pending", 32'(bus.pending), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrst_AN", 32'(bus.AN), 32'hFF);
    checkOutput("midrst_sseg", 32'(bus.sseg), 32'h7F);
    checkOutput("midrst_DP", 32'(bus.DP), 32'h1);
    checkOutput("midrst_pending", 32'(bus.pending), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_state(2);
    checkOutput("postrst_sseg", 32'(bus.sseg), 32'b1000000);
    checkOutput("postrst_DP", 32'(bus.DP), 32'h1);
    wait_state(2);
    checkOutput("postrst2_sseg", 32'(bus.sseg), 32'b1000000);
    checkOutput("postrst2_pending", 32'(bus.pending), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sseg_scan_ctrl.md
# sseg_scan_ctrl

- Time-multiplexed scan controller for the eight-digit common-anode seven-segment display.
- Latches a 32-bit hex value and per-digit decimal points through a load strobe, then cycles the anodes one digit at a time.
- Decodes each nibble to active-low segments, so no external decoder is needed.
- Sits between the value-producing logic (e.g. the binary-to-BCD converter) and the board pins, replacing switch-driven static anode selection.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot; minimum 2.
- BLANK_CYCLES, 2: cycles at the start of each slot with all anodes off (anti-ghosting); must be less than REFRESH_DIV.
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- load  in  1  single-cycle strobe; captures data_in and dp_in into the pending registers.
- data_in  in  32  digit i = data_in[4i+3:4i]; digit 0 is rightmost.
- dp_in  in  8  dp_in[i] = 1 lights the decimal point of digit i.
- en_mask  in  8  en_mask[i] = 0 keeps digit i dark; sampled live, not latched.
- pending  out  1  high while loaded data is waiting for frame commit.
- AN  out  8  active-low anode enables; at most one bit low.
- sseg  out  7  active-low segments, bit0 = a through bit6 = g.
- DP  out  1  active-low decimal point.

## Operation
- **Slot counter:** cnt counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0 and the digit index idx advances 0→7, then wraps 7→0. A frame is 8 slots.
- **Load:** load=1 writes pend_data and pend_dp and sets pending=1. A load while pending is already 1 overwrites the pending data (last write wins).
- **Commit:** occurs at the end-of-frame cycle, defined as cnt==REFRESH_DIV-1 and idx==7. If pending=1 in that cycle:
  - disp_data and disp_dp take the pending values and pending clears.
  - If load is also asserted in that cycle, the old pending value commits, the new value is captured, and pending stays 1 until the next frame.
- **Output, enabled slot:** applies when idx=i, cnt ≥ BLANK_CYCLES, en_mask[i]=1 and the digit is not blanked.
  - AN = ~(1<<i).
  - sseg = decode(disp_data[4i+3:4i]).
  - DP = ~disp_dp[i].
- **Output, otherwise:** AN=8'hFF, sseg=7'h7F, DP=1.
- **Decode (active-low):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- **Reset values:** AN=8'hFF, sseg=7'h7F, DP=1, pending=0. Internal state: cnt=0, idx=0, disp_data=0, disp_dp=0, pend_data=0, pend_dp=0.
- **Reset mid-frame:** asynchronous and immediate; pending data is discarded.
- **Output latency:** AN, sseg and DP are registered, so they reflect cnt/idx/en_mask one cycle later. All three change on the same edge, with no combinational path from inputs to outputs.
- **Load to pending:** pending rises the cycle after load.
- **Commit to display:** display data changes at the commit edge. It is visible starting with slot 0 of the next frame, after BLANK_CYCLES+1 cycles.
- **Worst-case load-to-display:** 8·REFRESH_DIV + BLANK_CYCLES + 1 cycles.
- **Dark time:** during the first BLANK_CYCLES cycles of every slot, plus one register cycle, AN=8'hFF.

## Configuration
- **LEADING_ZERO_BLANK_EN defined:**
  - Digits above the most significant nonzero nibble of disp_data are treated as blanked.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - A blanked digit's decimal point is also dark.
  - The leading-zero computation is registered at commit.
- **LEADING_ZERO_BLANK_EN undefined:** every digit with en_mask set shows its nibble, including leading zeros.

## Test plan
All scenarios use REFRESH_DIV=4, BLANK_CYCLES=1.
- **Reset:** hold reset_n=0 mid-slot → AN=FF, sseg=7F, DP=1, pending=0 immediately. After release, the first frame shows 0 on all enabled digits (macro off).
- **Basic scan:** load data_in=32'h89ABCDEF, dp_in=8'h01, en_mask=FF → pending=1 until the commit edge. The next frame cycles AN=FE,FD,…,7F, each low for 3 cycles after 1 dark cycle.
  - Digit 0: sseg=0001110 (F), DP=0.
  - Digit 7: sseg=0000000 (8), DP=1.
- **Masking:** en_mask=8'h0F → AN stays FF during slots 4–7. Slots 0–3 are unchanged.
- **Simultaneous load/commit:** load A in frame N. Load B exactly in the end-of-frame cycle → A is displayed in frame N+1 with pending=1, and B is displayed in frame N+2 with pending=0.
- **Overwrite:** two loads (32'h1, then 32'h2) within one frame → only 2 appears on digit 0. The value 1 is never displayed.
- **Leading-zero blanking (macro on):** load 32'h00000120 → digits 3–7 dark and digits 0–2 show 0, 2, 1. Loading 0 → only digit 0 lit, showing 1000000.
